nonce_result_fifo: RTL and testbench

Buffers golden-nonce results from the four `hyper_threading_core` instances so that results found while the host is busy are not lost. It sits between the cores' `id_nonce_out`/`hash_dify_out`/`irq` outputs and the SPI readback path. It captures each core's result on its `irq` rising edge and serialises simultaneous results into a single FIFO. It presents the oldest entry to `spi_slave` and pops it when a host result-read transaction completes.

---
 rtl/nonce_result_fifo_if.sv | 39 +++
 rtl/nonce_result_fifo.sv | 133 +++++++++++++
 tb/tb_nonce_result_fifo.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/nonce_result_fifo_if.sv
// Bundle of core-result inputs, SPI pop controls and FIFO head/status outputs
// shared between the result FIFO and whatever feeds and reads it.
interface nonce_result_fifo_if #(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = 40,
  parameter int HASH_W  = 32
);
  logic [3:0]              core_irq;
  logic [NONCE_W-1:0]      id_nonce_in_1, id_nonce_in_2, id_nonce_in_3, id_nonce_in_4;
  logic [HASH_W-1:0]       hash_dify_in_1, hash_dify_in_2, hash_dify_in_3, hash_dify_in_4;
  logic                    cs_n_1_4;
  logic                    rd_cmd;
  logic                    clr_ovf;
  logic [1:0]              head_core;
  logic [NONCE_W-1:0]      head_nonce;
  logic [HASH_W-1:0]       head_hash;
  logic [$clog2(DEPTH):0]  fifo_count;
  logic                    fifo_empty;
  logic                    fifo_full;
  logic                    overflow;
  logic [7:0]              drop_cnt;
  logic                    result_irq;

  modport master (
    output core_irq, id_nonce_in_1, id_nonce_in_2, id_nonce_in_3, id_nonce_in_4,
           hash_dify_in_1, hash_dify_in_2, hash_dify_in_3, hash_dify_in_4,
           cs_n_1_4, rd_cmd, clr_ovf,
    input  head_core, head_nonce, head_hash, fifo_count, fifo_empty, fifo_full,
           overflow, drop_cnt, result_irq
  );

  modport slave (
    input  core_irq, id_nonce_in_1, id_nonce_in_2, id_nonce_in_3, id_nonce_in_4,
           hash_dify_in_1, hash_dify_in_2, hash_dify_in_3, hash_dify_in_4,
           cs_n_1_4, rd_cmd, clr_ovf,
    output head_core, head_nonce, head_hash, fifo_count, fifo_empty, fifo_full,
           overflow, drop_cnt, result_irq
  );
endinterface

// File: rtl/nonce_result_fifo.sv
// Captures golden-nonce results from four cores on their irq rising edge,
// serialises them into one FIFO and pops the oldest on a host result read.
module nonce_result_fifo #(
  parameter int DEPTH   = 8,
  parameter int NONCE_W = 40,
  parameter int HASH_W  = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  nonce_result_fifo_if.slave   bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef struct packed {
    logic [1:0]         core;
    logic [NONCE_W-1:0] nonce;
    logic [HASH_W-1:0]  hash;
  } entry_t;

  logic [NONCE_W-1:0] nonce_in [4];
  logic [HASH_W-1:0]  hash_in  [4];
  entry_t             hold     [4];
  entry_t             mem      [DEPTH];
  entry_t             head;

  logic [3:0]       irq_d, pending, irq_rise, sel_mask, capture_ovf;
  logic [1:0]       sel;
  logic             sel_valid, push, pop, discard;
  logic             cs_s1, cs_s2, cs_s3;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_next;
  logic             empty_q, full_q, overflow_q;
  logic [7:0]       drop_q, drop_next;
  logic [2:0]       drop_inc;
  logic [8:0]       drop_sum;

  assign nonce_in[0] = bus.id_nonce_in_1;
  assign nonce_in[1] = bus.id_nonce_in_2;
  assign nonce_in[2] = bus.id_nonce_in_3;
  assign nonce_in[3] = bus.id_nonce_in_4;
  assign hash_in[0]  = bus.hash_dify_in_1;
  assign hash_in[1]  = bus.hash_dify_in_2;
  assign hash_in[2]  = bus.hash_dify_in_3;
  assign hash_in[3]  = bus.hash_dify_in_4;

  assign irq_rise = bus.core_irq & ~irq_d;

  // Descending scan so the lowest-index pending core wins.
  always_comb begin
    // NOTE: every combinational output gets a default first so no latch is inferred.
    sel_valid = 1'b0;
    sel       = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (pending[i]) begin
        sel_valid = 1'b1;
        sel       = 2'(i);
      end
    end
  end

  assign sel_mask    = sel_valid ? (4'b0001 << sel) : 4'b0000;
  assign pop         = cs_s2 & ~cs_s3 & bus.rd_cmd & ~empty_q;
  assign push        = sel_valid & (~full_q | pop);
  assign discard     = sel_valid & full_q & ~pop;
  // A new edge on a core whose held result is being pushed this cycle is not a loss.
  assign capture_ovf = irq_rise & pending & ~sel_mask;

  always_comb begin
    drop_inc = {2'b00, discard};
    for (int i = 0; i < 4; i++) drop_inc = drop_inc + {2'b00, capture_ovf[i]};
    drop_sum  = {1'b0, drop_q} + {6'd0, drop_inc};
    drop_next = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    count_next = count;
    if (push && !pop)      count_next = count + CNT_W'(1);
    else if (pop && !push) count_next = count - CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irq_d      <= '0;
      pending    <= '0;
      cs_s1      <= 1'b0;
      cs_s2      <= 1'b0;
      cs_s3      <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      irq_d   <= bus.core_irq;
      pending <= (pending & ~sel_mask) | irq_rise;
      cs_s1   <= bus.cs_n_1_4;
      cs_s2   <= cs_s1;
      cs_s3   <= cs_s2;
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count   <= count_next;
      empty_q <= (count_next == '0);
      full_q  <= (count_next == CNT_W'(DEPTH));
      if (bus.clr_ovf) begin
        overflow_q <= 1'b0;
        drop_q     <= '0;
      end else if (drop_inc != 3'd0) begin
        overflow_q <= 1'b1;
        drop_q     <= drop_next;
      end
    end
  end

  // NOTE: storage carries no reset; occupancy is governed solely by the pointers and count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (irq_rise[i]) hold[i] <= '{core: 2'(i), nonce: nonce_in[i], hash: hash_in[i]};
    end
    if (push) mem[wr_ptr] <= hold[sel];
  end

  assign head           = mem[rd_ptr];
  assign bus.head_core  = empty_q ? '0 : head.core;
  assign bus.head_nonce = empty_q ? '0 : head.nonce;
  assign bus.head_hash  = empty_q ? '0 : head.hash;
  assign bus.fifo_count = count;
  assign bus.fifo_empty = empty_q;
  assign bus.fifo_full  = full_q;
  assign bus.result_irq = ~empty_q;
  assign bus.overflow   = overflow_q;
  assign bus.drop_cnt   = drop_q;
endmodule

// File: tb/tb_nonce_result_fifo.sv
// Directed bench for nonce_result_fifo: table-driven single results plus
// hand-written sequences for arbitration, overflow, wrap, saturation and reset.
module tb_nonce_result_fifo;
  logic clk = 1'b0;
  logic reset_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  nonce_result_fifo_if #(.DEPTH(8), .NONCE_W(40), .HASH_W(32)) bus ();

  nonce_result_fifo #(.DEPTH(8), .NONCE_W(40), .HASH_W(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    int          core;
    logic [39:0] nonce;
    logic [31:0] hash;
    logic [1:0]  exp_core;
    logic [39:0] exp_nonce;
    logic [31:0] exp_hash;
  } vec_t;

  vec_t vecs [5];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_core(input int c, input logic [39:0] n, input logic [31:0] h);
    case (c)
      0: begin bus.id_nonce_in_1 = n; bus.hash_dify_in_1 = h; end
      1: begin bus.id_nonce_in_2 = n; bus.hash_dify_in_2 = h; end
      2: begin bus.id_nonce_in_3 = n; bus.hash_dify_in_3 = h; end
      default: begin bus.id_nonce_in_4 = n; bus.hash_dify_in_4 = h; end
    endcase
  endtask

  // Raise irq on the masked cores for one clock; on return their edges have been seen.
  task automatic fire(input logic [3:0] mask, input logic [39:0] base);
    for (int i = 0; i < 4; i++)
      if (mask[i]) set_core(i, base + 40'(i), 32'hCAFE_0000 + 32'(i));
    bus.core_irq = mask;
    tick();
    bus.core_irq = 4'h0;
  endtask

  // One SPI frame; on return the pop (if any) has committed on the 3rd edge after the cs rise.
  task automatic spi_frame(input logic rd);
    bus.rd_cmd   = rd;
    bus.cs_n_1_4 = 1'b0;
    repeat (3) tick();
    bus.cs_n_1_4 = 1'b1;
    repeat (3) tick();
    bus.rd_cmd   = 1'b0;
  endtask

  task automatic clear_ovf();
    bus.clr_ovf = 1'b1;
    tick();
    bus.clr_ovf = 1'b0;
    check("clr overflow", 64'(bus.overflow), 64'd0);
    check("clr drop_cnt", 64'(bus.drop_cnt), 64'd0);
  endtask

  task automatic fill_full(input logic [39:0] base_a, input logic [39:0] base_b);
    fire(4'hF, base_a);
    repeat (4) tick();
    fire(4'hF, base_b);
    repeat (4) tick();
  endtask

  initial begin
    vecs[0] = '{2, 40'h12_3456_789A, 32'h0000_FFFF, 2'd2, 40'h12_3456_789A, 32'h0000_FFFF};
    vecs[1] = '{0, 40'hFF_FFFF_FFFF, 32'hFFFF_FFFF, 2'd0, 40'hFF_FFFF_FFFF, 32'hFFFF_FFFF};
    vecs[2] = '{3, 40'h00_0000_0001, 32'h8000_0000, 2'd3, 40'h00_0000_0001, 32'h8000_0000};
    vecs[3] = '{1, 40'hA5_5A5A_A5A5, 32'h1234_5678, 2'd1, 40'hA5_5A5A_A5A5, 32'h1234_5678};
    vecs[4] = '{3, 40'h80_0000_0000, 32'h0000_0001, 2'd3, 40'h80_0000_0000, 32'h0000_0001};

    reset_n      = 1'b0;
    bus.core_irq = 4'h0;
    bus.cs_n_1_4 = 1'b1;
    bus.rd_cmd   = 1'b0;
    bus.clr_ovf  = 1'b0;
    for (int i = 0; i < 4; i++) set_core(i, 40'h0, 32'h0);
    repeat (3) tick();
    check("reset empty", 64'(bus.fifo_empty), 64'd1);
    check("reset full", 64'(bus.fifo_full), 64'd0);
    check("reset count", 64'(bus.fifo_count), 64'd0);
    check("reset irq", 64'(bus.result_irq), 64'd0);
    check("reset drop", 64'(bus.drop_cnt), 64'd0);
    reset_n = 1'b1;
    repeat (4) tick();

    // Single results, 20 push/pop pairs so both pointers wrap twice.
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 5; v++) begin
        set_core(vecs[v].core, vecs[v].nonce, vecs[v].hash);
        bus.core_irq[vecs[v].core] = 1'b1;
        tick();
        check("still empty at T", 64'(bus.fifo_empty), 64'd1);
        bus.core_irq = 4'h0;
        tick();
        check("single head_core", 64'(bus.head_core), 64'(vecs[v].exp_core));
        check("single head_nonce", 64'(bus.head_nonce), 64'(vecs[v].exp_nonce));
        check("single head_hash", 64'(bus.head_hash), 64'(vecs[v].exp_hash));
        check("single result_irq", 64'(bus.result_irq), 64'd1);
        spi_frame(1'b1);
        check("single popped empty", 64'(bus.fifo_empty), 64'd1);
      end
    end

    // Four simultaneous edges drain one per cycle in core order.
    fire(4'hF, 40'hA0);
    for (int k = 1; k <= 4; k++) begin
      tick();
      check("simul count", 64'(bus.fifo_count), 64'(k));
    end
    for (int k = 0; k < 4; k++) begin
      check("simul head_core", 64'(bus.head_core), 64'(k));
      check("simul head_nonce", 64'(bus.head_nonce), 64'h0A0 + 64'(k));
      spi_frame(1'b1);
    end
    check("simul drained", 64'(bus.fifo_empty), 64'd1);

    // Second edge on core 3 while its first result still waits behind cores 0..2.
    fire(4'hF, 40'hB0);
    tick();
    set_core(3, 40'hBF, 32'hCAFE_0003);
    bus.core_irq = 4'h8;
    tick();
    bus.core_irq = 4'h0;
    check("capture ovf flag", 64'(bus.overflow), 64'd1);
    check("capture ovf drop", 64'(bus.drop_cnt), 64'd1);
    repeat (2) tick();
    check("capture ovf count", 64'(bus.fifo_count), 64'd4);
    for (int k = 0; k < 3; k++) begin
      check("capture head_nonce", 64'(bus.head_nonce), 64'h0B0 + 64'(k));
      spi_frame(1'b1);
    end
    check("capture overwritten core", 64'(bus.head_core), 64'd3);
    check("capture overwritten nonce", 64'(bus.head_nonce), 64'h0BF);
    spi_frame(1'b1);
    clear_ovf();

    // Full FIFO: drop a push, then a push coincident with a pop is kept.
    fill_full(40'hC0, 40'hD0);
    check("full count", 64'(bus.fifo_count), 64'd8);
    check("full flag", 64'(bus.fifo_full), 64'd1);
    fire(4'h2, 40'hEE - 40'd1);
    tick();
    check("drop count", 64'(bus.fifo_count), 64'd8);
    check("drop overflow", 64'(bus.overflow), 64'd1);
    check("drop drop_cnt", 64'(bus.drop_cnt), 64'd1);
    bus.rd_cmd   = 1'b1;
    bus.cs_n_1_4 = 1'b0;
    repeat (3) tick();
    bus.cs_n_1_4 = 1'b1;
    tick();
    set_core(3, 40'hF3, 32'hCAFE_0003);
    bus.core_irq = 4'h8;
    tick();
    bus.core_irq = 4'h0;
    tick();
    bus.rd_cmd = 1'b0;
    check("pop+push count", 64'(bus.fifo_count), 64'd8);
    check("pop+push full", 64'(bus.fifo_full), 64'd1);
    check("pop+push no drop", 64'(bus.drop_cnt), 64'd1);
    begin
      logic [1:0]  exp_c [8];
      logic [39:0] exp_n [8];
      exp_c = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3};
      exp_n = '{40'hC1, 40'hC2, 40'hC3, 40'hD0, 40'hD1, 40'hD2, 40'hD3, 40'hF3};
      for (int k = 0; k < 8; k++) begin
        check("order head_core", 64'(bus.head_core), 64'(exp_c[k]));
        check("order head_nonce", 64'(bus.head_nonce), 64'(exp_n[k]));
        spi_frame(1'b1);
      end
    end
    check("order drained", 64'(bus.fifo_empty), 64'd1);
    clear_ovf();

    // 300 drops against a full FIFO saturate the counter.
    fill_full(40'h10, 40'h20);
    for (int k = 0; k < 75; k++) begin
      fire(4'hF, 40'h30);
      repeat (4) tick();
    end
    check("sat drop_cnt", 64'(bus.drop_cnt), 64'd255);
    check("sat overflow", 64'(bus.overflow), 64'd1);
    check("sat count", 64'(bus.fifo_count), 64'd8);
    clear_ovf();

    // Pop qualification: no rd_cmd, pop latency, and a read while empty.
    spi_frame(1'b0);
    check("no rd_cmd count", 64'(bus.fifo_count), 64'd8);
    check("no rd_cmd head", 64'(bus.head_nonce), 64'h010);
    bus.rd_cmd   = 1'b1;
    bus.cs_n_1_4 = 1'b0;
    repeat (3) tick();
    bus.cs_n_1_4 = 1'b1;
    repeat (2) tick();
    check("pop before 3rd edge", 64'(bus.fifo_count), 64'd8);
    tick();
    bus.rd_cmd = 1'b0;
    check("pop at 3rd edge", 64'(bus.fifo_count), 64'd7);
    check("pop next head", 64'(bus.head_nonce), 64'h011);
    repeat (7) spi_frame(1'b1);
    check("drained empty", 64'(bus.fifo_empty), 64'd1);
    spi_frame(1'b1);
    check("empty read count", 64'(bus.fifo_count), 64'd0);
    check("empty read flag", 64'(bus.fifo_empty), 64'd1);
    fire(4'h1, 40'h77);
    tick();
    check("after empty read head", 64'(bus.head_nonce), 64'h077);
    check("after empty read count", 64'(bus.fifo_count), 64'd1);

    // Asynchronous reset in the middle of a drain.
    fire(4'hF, 40'h50);
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset empty", 64'(bus.fifo_empty), 64'd1);
    check("async reset count", 64'(bus.fifo_count), 64'd0);
    check("async reset irq", 64'(bus.result_irq), 64'd0);
    check("async reset head_nonce", 64'(bus.head_nonce), 64'd0);
    check("async reset head_core", 64'(bus.head_core), 64'd0);
    check("async reset drop", 64'(bus.drop_cnt), 64'd0);
    tick();
    reset_n = 1'b1;
    repeat (4) tick();
    check("in-flight lost", 64'(bus.fifo_count), 64'd0);
    check("in-flight not counted", 64'(bus.overflow), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
